// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch path, the data path, the arbiter and the memory macro.
// The slave modport is the arbiter's view. The master modport is the CPU-plus-memory environment's view.
interface mem_arbiter_if;
  logic        start_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_ack_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [31:0] dm_rdata_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  modport slave (
    input  start_i, if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output start_i, if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
           mem_ack_i, mem_rdata_i,
    input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o, err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and data access.
// Data wins on conflict. The fetch anti-starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter #(
  parameter int TIMEOUT  = 16,
  parameter int MAX_WAIT = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);

  localparam int            CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  if (TIMEOUT < 2 || MAX_WAIT < 1) begin : g_param_check
    $error("mem_arbiter: TIMEOUT must be >= 2 and MAX_WAIT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          err_q, err_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;
  logic          starve;
  logic          grant, grant_dm;

  assign grant    = bus.start_i & (bus.if_req_i | bus.dm_req_i);
  assign grant_dm = bus.dm_req_i & ~(bus.if_req_i & starve);
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int            WW       = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [WW-1:0] wait_q, wait_d;

  assign starve = (wait_q == WAIT_MAX);

  // Counts data grants that fetch lost. A fetch grant clears the count.
  always_comb begin
    wait_d = wait_q;
    if (state_q == IDLE && grant) begin
      if (!grant_dm)
        wait_d = '0;
      else if (bus.if_req_i && !starve)
        wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) wait_q <= '0;
    else       wait_q <= wait_d;
  end
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its default first, so no branch can leave one unassigned and infer a latch.
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          owner_d = grant_dm ? OWN_DM : OWN_IF;
          we_d    = grant_dm & bus.dm_we_i;
          addr_d  = grant_dm ? bus.dm_addr_i : bus.if_addr_i;
          wdata_d = grant_dm ? bus.dm_wdata_i : '0;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      ACCESS: begin
        cnt_d = cnt_inc;
        // An ack in the same cycle as the timeout takes precedence.
        if (bus.mem_ack_i) begin
          state_d = DONE;
          if (owner_q == OWN_DM) dm_rdata_d = bus.mem_rdata_i;
          else                   if_rdata_d = bus.mem_rdata_i;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = DONE;
          err_d   = 1'b1;
          if (owner_q == OWN_DM) dm_rdata_d = '0;
          else                   if_rdata_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst_i) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.mem_req_o   = (state_q == ACCESS);
  assign bus.mem_we_o    = we_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.if_ack_o    = (state_q == DONE) && (owner_q == OWN_IF);
  assign bus.dm_ack_o    = (state_q == DONE) && (owner_q == OWN_DM);
  assign bus.err_o       = (state_q == DONE) && err_q;
  assign bus.if_rdata_o  = if_rdata_q;
  assign bus.dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios, then randomized traffic checked against a transaction-level model.
// The expected owner sequence follows MEM_ARB_STARVE_GUARD_EN when it is defined.
module tb_mem_arbiter;
  localparam int TIMEOUT  = 16;
  localparam int MAX_WAIT = 4;

  logic clk_i;
  logic rst_i;

  mem_arbiter_if b ();

  mem_arbiter #(.TIMEOUT(TIMEOUT), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (b)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int          n_checks;
  int          n_fail;
  int          wait_cnt;
  logic [31:0] exp_if_rd;
  logic [31:0] exp_dm_rd;
  int          mem_lat;
  logic [31:0] mem_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory macro: acks in ACCESS cycle mem_lat (1-based); 0 or beyond TIMEOUT never acks.
  initial begin : mem_model
    int acc;
    acc           = 0;
    b.mem_ack_i   = 1'b0;
    b.mem_rdata_i = '0;
    forever begin
      @(posedge clk_i); #1;
      if (b.mem_req_o) acc++;
      else             acc = 0;
      if (b.mem_req_o && acc == mem_lat) begin
        b.mem_ack_i   = 1'b1;
        b.mem_rdata_i = mem_data;
      end else begin
        b.mem_ack_i   = 1'b0;
        b.mem_rdata_i = $urandom;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog expired");
  end

  // Arbitration rule: data wins unless it is the only loser that has already lost MAX_WAIT times.
  function automatic bit model_pick_dm();
    bit starve;
    starve = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    starve = (wait_cnt >= MAX_WAIT);
`endif
    if (b.if_req_i && b.dm_req_i) return !starve;
    return b.dm_req_i;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ack"},    b.if_ack_o,    '0);
    check({tag, "_dm_ack"},    b.dm_ack_o,    '0);
    check({tag, "_err"},       b.err_o,       '0);
    check({tag, "_mem_req"},   b.mem_req_o,   '0);
    check({tag, "_mem_we"},    b.mem_we_o,    '0);
    check({tag, "_mem_addr"},  b.mem_addr_o,  '0);
    check({tag, "_mem_wdata"}, b.mem_wdata_o, '0);
    check({tag, "_if_rdata"},  b.if_rdata_o,  '0);
    check({tag, "_dm_rdata"},  b.dm_rdata_o,  '0);
  endtask

  task automatic idle_step();
    @(posedge clk_i); #1;
    check("idle_mem_req", b.mem_req_o, '0);
    check("idle_acks", {b.if_ack_o, b.dm_ack_o, b.err_o}, '0);
  endtask

  // Call in an IDLE cycle with requests already driven. Returns in the ack cycle.
  task automatic txn(input int lat, input logic [31:0] rd, output bit got_dm);
    bit          own_dm;
    bit          to;
    logic        we_e;
    logic [31:0] addr_e;
    logic [31:0] wd_e;
    logic [31:0] rd_e;
    int          acc_len;
    own_dm = model_pick_dm();
    we_e   = own_dm ? b.dm_we_i : 1'b0;
    addr_e = own_dm ? b.dm_addr_i : b.if_addr_i;
    wd_e   = b.dm_wdata_i;
`ifdef MEM_ARB_STARVE_GUARD_EN
    if (!own_dm)                               wait_cnt = 0;
    else if (b.if_req_i && wait_cnt < MAX_WAIT) wait_cnt++;
`endif
    to       = (lat < 1) || (lat > TIMEOUT);
    acc_len  = to ? TIMEOUT : lat;
    rd_e     = to ? 32'h0 : rd;
    mem_lat  = lat;
    mem_data = rd;
    for (int c = 1; c <= acc_len; c++) begin
      @(posedge clk_i); #1;
      check("acc_mem_req", b.mem_req_o, 32'd1);
      check("acc_mem_we", b.mem_we_o, we_e);
      check("acc_mem_addr", b.mem_addr_o, addr_e);
      if (own_dm) check("acc_mem_wdata", b.mem_wdata_o, wd_e);
      check("acc_no_ack", {b.if_ack_o, b.dm_ack_o, b.err_o}, '0);
      check("acc_if_rdata_hold", b.if_rdata_o, exp_if_rd);
      check("acc_dm_rdata_hold", b.dm_rdata_o, exp_dm_rd);
    end
    @(posedge clk_i); #1;
    if (own_dm) exp_dm_rd = rd_e;
    else        exp_if_rd = rd_e;
    check("done_mem_req", b.mem_req_o, '0);
    check("done_if_ack", b.if_ack_o, !own_dm);
    check("done_dm_ack", b.dm_ack_o, own_dm);
    check("done_err", b.err_o, to);
    check("done_if_rdata", b.if_rdata_o, exp_if_rd);
    check("done_dm_rdata", b.dm_rdata_o, exp_dm_rd);
    got_dm = b.dm_ack_o;
  endtask

  task automatic new_if();
    b.if_req_i  = 1'b1;
    b.if_addr_i = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic new_dm();
    b.dm_req_i   = 1'b1;
    b.dm_we_i    = 1'($urandom_range(0, 1));
    b.dm_addr_i  = $urandom & 32'hFFFF_FFFC;
    b.dm_wdata_i = $urandom;
  endtask

  initial begin : main
    bit got;
    int lat;
    int r;
    n_checks  = 0;
    n_fail    = 0;
    wait_cnt  = 0;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    mem_lat   = 0;
    mem_data  = '0;
    rst_i        = 1'b1;
    b.start_i    = 1'b0;
    b.if_req_i   = 1'b0;
    b.if_addr_i  = '0;
    b.dm_req_i   = 1'b0;
    b.dm_we_i    = 1'b0;
    b.dm_addr_i  = '0;
    b.dm_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("reset");
    rst_i     = 1'b0;
    b.start_i = 1'b1;
    @(posedge clk_i); #1;

    // Single fetch, memory acks in the first ACCESS cycle.
    b.if_req_i  = 1'b1;
    b.if_addr_i = 32'h10;
    txn(1, 32'h00A0_0093, got);
    check("single_fetch_owner", got, '0);
    b.if_req_i = 1'b0;
    idle_step();

    // Simultaneous fetch and store: the store is served first.
    new_if();
    b.dm_req_i   = 1'b1;
    b.dm_we_i    = 1'b1;
    b.dm_addr_i  = 32'h20;
    b.dm_wdata_i = 32'hDEAD_BEEF;
    txn(3, $urandom, got);
    check("simul_first_dm", got, 32'd1);
    b.dm_req_i = 1'b0;
    idle_step();
    txn(3, $urandom, got);
    check("simul_second_if", got, '0);
    b.if_req_i = 1'b0;
    idle_step();

    // A load that is never acknowledged times out.
    new_dm();
    b.dm_we_i = 1'b0;
    txn(0, $urandom, got);
    check("timeout_owner", got, 32'd1);
    b.dm_req_i = 1'b0;
    idle_step();

    // An ack in the timeout cycle wins over the timeout.
    new_dm();
    b.dm_we_i = 1'b0;
    txn(TIMEOUT, $urandom, got);
    b.dm_req_i = 1'b0;
    idle_step();

    // With start_i low, a pending fetch is not granted.
    b.start_i = 1'b0;
    new_if();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i); #1;
      check("gate_no_mem_req", b.mem_req_o, '0);
    end
    b.start_i = 1'b1;
    txn(2, $urandom, got);
    b.if_req_i = 1'b0;
    idle_step();

    // Reset in the third ACCESS cycle of a fetch, coinciding with the memory ack.
    new_if();
    mem_lat  = 3;
    mem_data = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("rst_mid_mem_req", b.mem_req_o, 32'd1);
    end
    rst_i      = 1'b1;
    b.if_req_i = 1'b0;
    @(posedge clk_i); #1;
    check_all_zero("rst_mid");
    rst_i     = 1'b0;
    wait_cnt  = 0;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    repeat (3) idle_step();
    new_if();
    txn(2, $urandom, got);
    check("post_rst_owner", got, '0);
    b.if_req_i = 1'b0;
    idle_step();

    // Both requests held continuously: owner order follows the starvation rule.
    new_if();
    new_dm();
    for (int i = 0; i < 10; i++) begin
      bit exp_dm;
      exp_dm = 1'b1;
`ifdef MEM_ARB_STARVE_GUARD_EN
      exp_dm = (i % 5) != 4;
`endif
      txn($urandom_range(1, 3), $urandom, got);
      check("starve_owner", got, exp_dm);
      if (got) new_dm();
      else     new_if();
      idle_step();
    end
    b.if_req_i = 1'b0;
    b.dm_req_i = 1'b0;
    idle_step();

    // Randomized traffic checked against the model.
    for (int i = 0; i < 40; i++) begin
      if (!b.if_req_i && !b.dm_req_i) begin
        r = $urandom_range(1, 3);
        if (r != 2) new_if();
        if (r != 1) new_dm();
      end
      r = $urandom_range(0, 9);
      if      (r == 0) lat = 0;
      else if (r == 1) lat = TIMEOUT;
      else if (r == 2) lat = TIMEOUT + 1;
      else             lat = $urandom_range(1, 4);
      txn(lat, $urandom, got);
      if (got) begin
        if ($urandom_range(0, 1) == 1) new_dm();
        else                           b.dm_req_i = 1'b0;
      end else begin
        if ($urandom_range(0, 1) == 1) new_if();
        else                           b.if_req_i = 1'b0;
      end
      if (!b.if_req_i && $urandom_range(0, 2) == 0) new_if();
      if (!b.dm_req_i && $urandom_range(0, 2) == 0) new_dm();
      idle_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
